// File: rtl/dcsk_pkg.sv
// ---------------------------------------------------------------------------
// dcsk_pkg
// Shared definitions for the DCSK modulator and its matching demodulator:
// FSM state encoding, spread-factor decode, chaos LFSR seed/taps and the
// default frame geometry.
// ---------------------------------------------------------------------------
package dcsk_pkg;

    localparam int          DATA_W        = 32;
    localparam int          MAX_SF        = 16;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 in right-shift form:
    // feedback = s[0]^s[2]^s[3]^s[5], fed into bit 15.
    localparam logic [15:0] LFSR_TAPS     = 16'h002D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REF  = 2'd1,
        INFO = 2'd2
    } state_t;

    // Spread_Factor_Sel encoding shared with the receiver.
    function automatic logic [4:0] sf_from_sel(input logic [1:0] sel);
        logic [4:0] sf;
        case (sel)
            2'd0:    sf = 5'd2;
            2'd1:    sf = 5'd4;
            2'd2:    sf = 5'd8;
            default: sf = 5'd16;
        endcase
        return sf;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/dcsk_modulator_if.sv
// ---------------------------------------------------------------------------
// dcsk_modulator_if
// Word-in / chip-out bus of the DCSK modulator.
//   In_Data, In_Valid, In_Ready, Spread_Factor_Sel : word handshake
//   Out_Mod_Data, Out_Valid, Frame_Done            : chip stream
//   Seed_Load, Seed (only with DCSK_MOD_SEED_LOAD_EN) : LFSR reseed
// slave  = modulator side, master = word source / chip sink.
// ---------------------------------------------------------------------------
interface dcsk_modulator_if #(
    parameter int DATA_W = dcsk_pkg::DATA_W
);
    logic [DATA_W-1:0] In_Data;
    logic              In_Valid;
    logic              In_Ready;
    logic [1:0]        Spread_Factor_Sel;
    logic              Out_Mod_Data;
    logic              Out_Valid;
    logic              Frame_Done;
`ifdef DCSK_MOD_SEED_LOAD_EN
    logic              Seed_Load;
    logic [15:0]       Seed;

    modport slave (
        input  In_Data, In_Valid, Spread_Factor_Sel, Seed_Load, Seed,
        output In_Ready, Out_Mod_Data, Out_Valid, Frame_Done
    );
    modport master (
        output In_Data, In_Valid, Spread_Factor_Sel, Seed_Load, Seed,
        input  In_Ready, Out_Mod_Data, Out_Valid, Frame_Done
    );
`else
    modport slave (
        input  In_Data, In_Valid, Spread_Factor_Sel,
        output In_Ready, Out_Mod_Data, Out_Valid, Frame_Done
    );
    modport master (
        output In_Data, In_Valid, Spread_Factor_Sel,
        input  In_Ready, Out_Mod_Data, Out_Valid, Frame_Done
    );
`endif
endinterface

// File: rtl/dcsk_chaos_lfsr.sv
// ---------------------------------------------------------------------------
// dcsk_chaos_lfsr
// 16-bit Fibonacci LFSR used as the chaotic reference source.
//   Clk, Rst  : clock, synchronous active-high reset (loads SEED)
//   En        : advance one step
//   Load      : load Load_Val (wins over En)
//   Chip      : current output chip, lfsr[0]
// ---------------------------------------------------------------------------
module dcsk_chaos_lfsr #(
    parameter logic [15:0] SEED = dcsk_pkg::LFSR_SEED_DEF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        En,
    input  logic        Load,
    input  logic [15:0] Load_Val,
    output logic        Chip
);
    import dcsk_pkg::*;

    logic [15:0] lfsr;

    always_ff @(posedge Clk) begin
        if (Rst)       lfsr <= SEED;
        else if (Load) lfsr <= Load_Val;
        else if (En)   lfsr <= lfsr_next(lfsr);
    end

    assign Chip = lfsr[0];

endmodule

// File: rtl/dcsk_modulator.sv
// ---------------------------------------------------------------------------
// dcsk_modulator
// DCSK transmitter. Each information bit (LSB first) becomes a reference
// slot of SF chaotic chips followed by an information slot that repeats the
// reference (bit=1) or inverts it (bit=0). 64*SF chips per word.
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : dcsk_modulator_if.slave (handshake, sel, chip stream)
// Optional build macro: DCSK_MOD_SEED_LOAD_EN adds Seed_Load/Seed to reload
// the chaos LFSR while idle.
// ---------------------------------------------------------------------------
module dcsk_modulator #(
    parameter int          DATA_W    = dcsk_pkg::DATA_W,
    parameter int          MAX_SF    = dcsk_pkg::MAX_SF,
    parameter logic [15:0] LFSR_SEED = dcsk_pkg::LFSR_SEED_DEF
) (
    input logic           Clk,
    input logic           Rst,
    dcsk_modulator_if.slave bus
);
    import dcsk_pkg::*;

    localparam int CNT_W = $clog2(MAX_SF) + 1;
    localparam int IDX_W = $clog2(MAX_SF);
    localparam int BIT_W = $clog2(DATA_W);

    state_t            state;
    logic [DATA_W-1:0] word;
    logic [CNT_W-1:0]  sf;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [MAX_SF-1:0] dly;
    logic              out_data;
    logic              out_valid;
    logic              frame_done;

    logic              chip_lfsr;
    logic              lfsr_en;
    logic              seed_req;
    logic [15:0]       load_val;
    logic              slot_end;
    logic              last_bit;
    logic              word_end;
    logic              accept;
    logic [CNT_W-1:0]  info_k;
    logic [IDX_W-1:0]  dly_idx;
    logic              info_chip;

    // cnt indexes the chip currently on the output register.
    assign slot_end = (cnt == sf - CNT_W'(1));
    assign last_bit = (bit_idx == BIT_W'(DATA_W - 1));
    assign word_end = (state == INFO) && slot_end && last_bit;

`ifdef DCSK_MOD_SEED_LOAD_EN
    assign seed_req = (state == IDLE) && bus.Seed_Load;
    assign load_val = (bus.Seed == 16'h0000) ? LFSR_SEED : bus.Seed;
`else
    assign seed_req = 1'b0;
    assign load_val = LFSR_SEED;
`endif

    // Ready during the last chip of a word lets the next word start on the
    // very next edge, keeping the chip stream gapless.
    assign bus.In_Ready = ((state == IDLE) && !seed_req) || word_end;
    assign accept       = bus.In_Valid && bus.In_Ready;

    // Advance whenever the chip registered on this edge is a REF chip.
    assign lfsr_en = accept
                   || ((state == REF) && !slot_end)
                   || ((state == INFO) && slot_end && !last_bit);

    // INFO chip k reuses reference chip k, which sits at dly[SF-1-k] once
    // all SF reference chips have been shifted in.
    assign info_k    = (state == REF) ? '0 : cnt + CNT_W'(1);
    assign dly_idx   = IDX_W'(sf - CNT_W'(1) - info_k);
    assign info_chip = ~(dly[dly_idx] ^ word[bit_idx]);

    dcsk_chaos_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .Clk      (Clk),
        .Rst      (Rst),
        .En       (lfsr_en),
        .Load     (seed_req),
        .Load_Val (load_val),
        .Chip     (chip_lfsr)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            word       <= '0;
            sf         <= CNT_W'(2);
            cnt        <= '0;
            bit_idx    <= '0;
            dly        <= '0;
            out_data   <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (lfsr_en) dly <= {dly[MAX_SF-2:0], chip_lfsr};

            if (accept) begin
                // Only possible in IDLE or on the final chip of a word.
                state     <= REF;
                word      <= bus.In_Data;
                sf        <= CNT_W'(sf_from_sel(bus.Spread_Factor_Sel));
                cnt       <= '0;
                bit_idx   <= '0;
                out_data  <= chip_lfsr;
                out_valid <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        out_data  <= 1'b0;
                        out_valid <= 1'b0;
                    end
                    REF: begin
                        if (slot_end) begin
                            state    <= INFO;
                            cnt      <= '0;
                            out_data <= info_chip;
                        end else begin
                            cnt      <= cnt + CNT_W'(1);
                            out_data <= chip_lfsr;
                        end
                    end
                    INFO: begin
                        if (!slot_end) begin
                            cnt        <= cnt + CNT_W'(1);
                            out_data   <= info_chip;
                            frame_done <= last_bit && (cnt + CNT_W'(1) == sf - CNT_W'(1));
                        end else if (!last_bit) begin
                            state    <= REF;
                            cnt      <= '0;
                            bit_idx  <= bit_idx + BIT_W'(1);
                            out_data <= chip_lfsr;
                        end else begin
                            state     <= IDLE;
                            cnt       <= '0;
                            bit_idx   <= '0;
                            out_data  <= 1'b0;
                            out_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_data  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.Out_Mod_Data = out_data;
    assign bus.Out_Valid    = out_valid;
    assign bus.Frame_Done   = frame_done;

endmodule

// File: tb/tb_dcsk_modulator.sv
module tb_dcsk_modulator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcsk_modulator_if bus ();

    dcsk_modulator dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        int          sf;
        int          exp_len;
    } vec_t;

    vec_t        vecs [14];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_lfsr;
    bit          mon_en = 1'b0;
    logic        chips [$];
    int          fd_idx [$];
    int          rdy_idx [$];

    // Records every valid chip plus where Frame_Done / In_Ready were seen.
    always @(negedge clk) begin
        if (mon_en && bus.Out_Valid) begin
            if (bus.Frame_Done) fd_idx.push_back(chips.size());
            if (bus.In_Ready)   rdy_idx.push_back(chips.size());
            chips.push_back(bus.Out_Mod_Data);
        end
    end

    function automatic logic [15:0] tb_lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_word(input logic [1:0] sel, input logic [31:0] data, input string name);
        int n;
        chips.delete(); fd_idx.delete(); rdy_idx.delete();
        mon_en = 1'b1;
        @(negedge clk);
        n = 0;
        while (!bus.In_Ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready"}, bus.In_Ready, 1);
        bus.In_Valid          = 1'b1;
        bus.In_Data           = data;
        bus.Spread_Factor_Sel = sel;
        @(negedge clk);
        // Changes after accept must not affect the word in flight.
        bus.In_Valid          = 1'b0;
        bus.In_Data           = ~data;
        bus.Spread_Factor_Sel = sel + 2'd1;
        chk({name, "_latency"}, bus.Out_Valid, 1);
        n = 0;
        while (bus.Out_Valid && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ends"}, bus.Out_Valid, 0);
        mon_en = 1'b0;
    endtask

    task automatic check_first8(input string name);
        logic [7:0] got;
        logic [7:0] want;
        want = 8'b1100_0101;  // chips 0..7 = 1,0,1,0,0,0,1,1
        got  = '0;
        for (int i = 0; i < 8; i++) if (i < chips.size()) got[i] = chips[i];
        chk({name, "_first8"}, got, want);
    endtask

    task automatic check_words(input string name, input int sf, input int exp_len,
                               input logic [31:0] w0, input logic [31:0] w1, input int nw);
        int          idx;
        int          bad;
        logic [31:0] w;
        logic [31:0] dec;
        logic [15:0] rv;
        logic        c;
        chk({name, "_len"}, chips.size(), exp_len);
        idx = 0;
        bad = 0;
        rv  = '0;
        for (int j = 0; j < nw; j++) begin
            w   = (j == 0) ? w0 : w1;
            dec = '0;
            for (int b = 0; b < 32; b++) begin
                for (int k = 0; k < sf; k++) begin
                    rv[k]  = m_lfsr[0];
                    m_lfsr = tb_lfsr_step(m_lfsr);
                    if (idx >= chips.size() || chips[idx] !== rv[k]) bad++;
                    idx++;
                end
                for (int k = 0; k < sf; k++) begin
                    c = ~(rv[k] ^ w[b]);
                    if (idx >= chips.size() || chips[idx] !== c) bad++;
                    // Demodulate against the DUT's own reference slot.
                    if (k == 0 && idx < chips.size()) dec[b] = (chips[idx] === chips[idx - sf]);
                    idx++;
                end
            end
            chk({name, "_decode"}, dec, w);
            chk({name, "_fd_pos"}, (j < fd_idx.size()) ? fd_idx[j] : -1, (j + 1) * 64 * sf - 1);
            chk({name, "_rdy_pos"}, (j < rdy_idx.size()) ? rdy_idx[j] : -1, (j + 1) * 64 * sf - 1);
        end
        chk({name, "_chip_errs"}, bad, 0);
        chk({name, "_fd_count"}, fd_idx.size(), nw);
        chk({name, "_rdy_count"}, rdy_idx.size(), nw);
    endtask

    initial begin
        int acc;
        int n;

        vecs[0]  = '{2'd0, 32'h0000_0001,  2,  128};
        vecs[1]  = '{2'd3, 32'hFFFF_FFFF, 16, 1024};
        vecs[2]  = '{2'd0, 32'hA5A5_3C3C,  2,  128};
        vecs[3]  = '{2'd0, 32'h0000_0000,  2,  128};
        vecs[4]  = '{2'd0, 32'hFFFF_FFFF,  2,  128};
        vecs[5]  = '{2'd1, 32'hA5A5_3C3C,  4,  256};
        vecs[6]  = '{2'd1, 32'h0000_0000,  4,  256};
        vecs[7]  = '{2'd1, 32'hFFFF_FFFF,  4,  256};
        vecs[8]  = '{2'd2, 32'hA5A5_3C3C,  8,  512};
        vecs[9]  = '{2'd2, 32'h0000_0000,  8,  512};
        vecs[10] = '{2'd2, 32'hFFFF_FFFF,  8,  512};
        vecs[11] = '{2'd3, 32'hA5A5_3C3C, 16, 1024};
        vecs[12] = '{2'd3, 32'h0000_0000, 16, 1024};
        vecs[13] = '{2'd3, 32'hFFFF_FFFF, 16, 1024};

        bus.In_Valid          = 1'b0;
        bus.In_Data           = '0;
        bus.Spread_Factor_Sel = 2'd0;
`ifdef DCSK_MOD_SEED_LOAD_EN
        bus.Seed_Load = 1'b0;
        bus.Seed      = 16'h0000;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        m_lfsr = 16'hACE1;

        chk("rst_out_valid", bus.Out_Valid, 0);
        chk("rst_out_data", bus.Out_Mod_Data, 0);
        chk("rst_frame_done", bus.Frame_Done, 0);
        chk("rst_in_ready", bus.In_Ready, 1);

        for (int i = 0; i < 14; i++) begin
            run_word(vecs[i].sel, vecs[i].data, $sformatf("v%0d", i));
            if (i == 0) check_first8("v0");
            check_words($sformatf("v%0d", i), vecs[i].sf, vecs[i].exp_len, vecs[i].data, 32'h0, 1);
        end

        // Back-to-back words with In_Valid held high, SF=4.
        chips.delete(); fd_idx.delete(); rdy_idx.delete();
        mon_en = 1'b1;
        @(negedge clk);
        bus.In_Valid          = 1'b1;
        bus.In_Data           = 32'h1234_5678;
        bus.Spread_Factor_Sel = 2'd1;
        acc = 0;
        n   = 0;
        while (acc < 2 && n < 1000) begin
            if (bus.In_Ready) acc++;
            @(negedge clk);
            n++;
            if (acc == 1) bus.In_Data = 32'hA5A5_3C3C;
        end
        bus.In_Valid          = 1'b0;
        bus.Spread_Factor_Sel = 2'd3;
        chk("b2b_accepts", acc, 2);
        n = 0;
        while (bus.Out_Valid && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_ends", bus.Out_Valid, 0);
        mon_en = 1'b0;
        check_words("b2b", 4, 512, 32'h1234_5678, 32'hA5A5_3C3C, 2);

        // Reset at chip 37 of an SF=8 word.
        @(negedge clk);
        bus.In_Valid          = 1'b1;
        bus.In_Data           = 32'h0000_00F0;
        bus.Spread_Factor_Sel = 2'd2;
        @(negedge clk);
        bus.In_Valid = 1'b0;
        repeat (37) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", bus.Out_Valid, 0);
        chk("midrst_in_ready", bus.In_Ready, 1);
        chk("midrst_frame_done", bus.Frame_Done, 0);
        chk("midrst_out_data", bus.Out_Mod_Data, 0);
        rst    = 1'b0;
        m_lfsr = 16'hACE1;
        run_word(2'd0, 32'h0000_0001, "restart");
        check_first8("restart");
        check_words("restart", 2, 128, 32'h0000_0001, 32'h0, 1);

`ifdef DCSK_MOD_SEED_LOAD_EN
        @(negedge clk);
        bus.Seed_Load = 1'b1;
        bus.Seed      = 16'h0001;
        bus.In_Valid  = 1'b1;
        #1;
        chk("seed_blocks_ready", bus.In_Ready, 0);
        @(negedge clk);
        bus.Seed_Load = 1'b0;
        bus.In_Valid  = 1'b0;
        m_lfsr        = 16'h0001;
        run_word(2'd1, 32'hA5A5_3C3C, "seed1");
        check_words("seed1", 4, 256, 32'hA5A5_3C3C, 32'h0, 1);
        @(negedge clk);
        bus.Seed_Load = 1'b1;
        bus.Seed      = 16'h0000;
        @(negedge clk);
        bus.Seed_Load = 1'b0;
        m_lfsr        = 16'hACE1;
        run_word(2'd0, 32'h0000_0001, "seed0");
        check_first8("seed0");
        check_words("seed0", 2, 128, 32'h0000_0001, 32'h0, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcsk_modulator.md
Name: dcsk_modulator

Overview:
DCSK transmitter: accepts 32-bit information words and emits a 1-bit chip stream. Each information bit occupies two slots of SF chips each: a chaotic reference slot, then an information slot. The information slot repeats the reference for bit=1 and inverts it for bit=0. Output feeds the channel/loopback into the DCSK demodulator, which uses the same Spread_Factor_Sel encoding and LSB-first bit order.

Parameters:
DATA_W, 32, information word width (bits per frame)
MAX_SF, 16, maximum spread factor; sizes the reference delay register
LFSR_SEED, 16'hACE1, chaos generator reset seed (must be nonzero)

Ports:
Clk  in  1  clock
Rst  in  1  synchronous, active-high reset
In_Data  in  32  information word
In_Valid  in  1  In_Data valid
In_Ready  out  1  modulator can accept a word this cycle
Spread_Factor_Sel  in  2  0->SF=2, 1->4, 2->8, 3->16; sampled only at word accept
Out_Mod_Data  out  1  modulated chip
Out_Valid  out  1  Out_Mod_Data carries a valid chip
Frame_Done  out  1  one-cycle pulse with the last chip of a word

Behaviour:
- One clock, Clk. Reset is synchronous and active-high (Rst). Reset values: state IDLE, Out_Mod_Data=0, Out_Valid=0, Frame_Done=0, bit index=0, chip counter=0, LFSR=LFSR_SEED, delay register=0.
- Accept: a word is accepted on a Clk edge where In_Valid & In_Ready.
  - In_Ready=1 combinationally in IDLE, and in the cycle the last chip of a word is being registered; otherwise 0.
  - At accept, In_Data is latched and SF is latched from Spread_Factor_Sel. Both are held for the whole word.
- FSM states: IDLE, REF, INFO.
  - IDLE -> REF on accept.
  - REF -> INFO after SF chips.
  - INFO -> REF after SF chips, if bits remain.
  - INFO (last bit) -> REF if a new word is accepted in that cycle, else IDLE.
- Latency: first REF chip is valid on Out_Mod_Data/Out_Valid on the cycle after accept. Outputs are registered. Out_Valid stays 1 continuously through a word, with no gaps. Back-to-back words produce an unbroken chip stream.
- REF chip k (0..SF-1):
  - Chip = LFSR[0]. The LFSR then advances one step.
  - LFSR is Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - The chip is shifted into the delay register.
  - The LFSR advances only in REF; it never re-seeds between words.
- INFO chip k: chip = delayed reference chip k XNOR'd with the current info bit. Bit=1 gives an identical chip; bit=0 gives an inverted chip.
- Bit order: LSB first. Bit index 0..31 increments after each INFO slot. Frame_Done=1 together with chip 2*SF-1 of bit 31.
- Word duration: exactly 64*SF Out_Valid cycles (128/256/512/1024).
- Spread_Factor_Sel changes mid-word: ignored until the next accept.
- In_Valid deasserting mid-word: ignored (the word is already latched).
- Rst mid-word: aborts immediately. Next cycle shows reset values; the partial frame is not resumed.
- Chip counter width is log2(MAX_SF)+1. SF=16 must not wrap early.

Optional Feature:
DCSK_MOD_SEED_LOAD_EN
- Enabled: adds ports Seed_Load (in, 1) and Seed (in, 16).
  - Seed_Load=1 in IDLE loads the LFSR with Seed in that cycle; Seed=0 is replaced by LFSR_SEED.
  - Seed_Load outside IDLE is ignored.
  - Seed_Load takes priority over accept: In_Ready=0 while Seed_Load=1.
- Disabled: ports absent. The LFSR seeds only from LFSR_SEED at reset.

Decomposition:
- Package dcsk_pkg:
  - state enum (IDLE/REF/INFO)
  - function mapping the 2-bit sel to a 5-bit SF (shared with the receiver)
  - LFSR_SEED default and tap constants
  - DATA_W and MAX_SF constants
- Sub-module dcsk_chaos_lfsr:
  - ports: Clk, Rst, En, Load, Load_Val
  - output: chip bit
  - instantiated once.

Test Plan:
- Reset, then In_Valid=1, In_Data=32'h0000_0001, sel=0:
  - Out_Valid rises one cycle after accept; first 4 chips are r0 r1 r0 r1.
  - Next 4 chips are r2 r3 ~r2 ~r3, where r* come from the LFSR starting at seed 16'hACE1.
  - Frame_Done pulses on Out_Valid cycle 128.
- sel=3, word 32'hFFFF_FFFF: every INFO slot equals the preceding 16 REF chips; exactly 1024 valid chips, then IDLE.
- Two words, In_Valid held high, sel=1:
  - In_Ready pulses on the last chip of word 1.
  - Out_Valid never drops across the boundary; 512 contiguous chips total.
- Rst asserted at chip 37 of a sel=2 word:
  - Next cycle Out_Valid=0, In_Ready=1, LFSR=16'hACE1.
  - A new word restarts from bit 0.
- Loopback into the DCSK demodulator across all four sel values with 32'hA5A5_3C3C, 32'h0, 32'hFFFF_FFFF: the decoded word matches.
- (With DCSK_MOD_SEED_LOAD_EN) Seed_Load with Seed=16'h0001 in IDLE: the first REF chips follow the LFSR sequence from 16'h0001. Seed=0 yields the 16'hACE1 sequence.
